cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run-control sequencer for the RISC-V core: owns the core's step enable and reset and decides, cycle by cycle, whether the core advances. It merges UART-bridge start/halt/reset commands, the debounced single-step button and the force-halt switch. It also applies an optional PC breakpoint. The block sits in the CPU clock domain between the bridge/button logic and `riscv_core` (`cpu_step_in`, `rst_in`), and replaces ad-hoc halt/run logic at the top level.

## Interface
- `RESET_CYCLES`, default 16: number of cycles the core reset is held after a reset request (≥1).
- `clk_in` input 1: CPU clock (50 MHz).
- `rst_in` input 1: asynchronous, active-high reset.
- `start_in` input 1: single-cycle pulse; enter RUN.
- `halt_in` input 1: single-cycle pulse; enter HALT.
- `reset_req_in` input 1: single-cycle pulse; reset the core.
- `step_in` input 1: single-cycle pulse; execute one step while halted.
- `force_halt_in` input 1: level; while high, RUN is not permitted.
- `pc_in` input 32: current core PC (`imem_addr_out`).
- `bp_addr_in` input 32: breakpoint address (word aligned; bits [1:0] ignored).
- `bp_en_in` input 1: level; breakpoint enable.
- `cpu_step_out` output 1: core step enable.
- `cpu_rst_out` output 1: core reset, active high.
- `state_out` output 2: 0 = HALT, 1 = RUN, 2 = STEP, 3 = RESETTING.
- `bp_hit_out` output 1: sticky flag; the last halt was caused by the breakpoint.
- `step_count_out` output 32: number of cycles with `cpu_step_out` = 1 since the last core reset.

## Operation
- States: HALT, RUN, STEP, RESETTING. All state, counter and flag registers are updated on `posedge clk_in`.
- Command priority when several commands arrive in the same cycle: `reset_req_in` > (`halt_in` | `force_halt_in`) > `start_in` > `step_in`. Commands not valid in the current state are ignored; they are not queued.
- RESETTING:
  - `cpu_rst_out` = 1 and `cpu_step_out` = 0; the reset counter counts down from `RESET_CYCLES`-1.
  - At zero, go to HALT and clear `step_count_out` and `bp_hit_out`.
  - A `reset_req_in` during RESETTING reloads the counter.
- HALT:
  - `cpu_step_out` = 0.
  - `start_in` with `force_halt_in` = 0 → RUN. `start_in` with `force_halt_in` = 1 is ignored.
  - `step_in` → STEP. Stepping is allowed while `force_halt_in` = 1.
  - `start_in` and `step_in` both clear `bp_hit_out`.
- STEP: `cpu_step_out` = 1 for exactly one cycle, then unconditionally HALT. A reset request takes precedence.
- RUN:
  - `cpu_step_out` = 1 every cycle unless a breakpoint hit occurs.
  - `halt_in` or `force_halt_in` → HALT. `cpu_step_out` is still 1 in the cycle the command is sampled.
- Breakpoint (when compiled in):
  - hit = RUN & `bp_en_in` & armed & (`pc_in`[31:2] == `bp_addr_in`[31:2]).
  - `cpu_step_out` is computed combinationally as 0 in the hit cycle, so the instruction at the breakpoint does not step.
  - On a hit: next state is HALT, `bp_hit_out` ← 1, armed ← 0.
  - armed ← 1 whenever `pc_in` ≠ breakpoint address. This makes `start_in` from a breakpoint resume past it.
  - armed resets to 1.
- `step_count_out` increments by 1 on every cycle with `cpu_step_out` = 1 and wraps modulo 2^32.
- Outputs other than `cpu_step_out` are registered.

## Timing
- `rst_in` assertion immediately forces:
  - state = RESETTING, counter = `RESET_CYCLES`-1;
  - `cpu_rst_out` = 1, `cpu_step_out` = 0, `state_out` = 3;
  - `bp_hit_out` = 0, `step_count_out` = 0.
- After `rst_in` deasserts, `cpu_rst_out` stays high for exactly `RESET_CYCLES` rising edges, then HALT.
- Command pulse at edge N → new state and outputs are visible after edge N. Examples: `start_in` gives `cpu_step_out` = 1 from cycle N+1; `step_in` gives exactly one high cycle, N+1.
- `halt_in` at edge N: the last step cycle is N; `cpu_step_out` = 0 from N+1.
- Breakpoint: the path from `pc_in` to `cpu_step_out` is combinational, with zero latency.
- Reset mid-STEP or mid-RUN: `cpu_step_out` drops in the same cycle as `cpu_rst_out` rises.

## Configuration
- `CPU_RUN_CTRL_BREAKPOINT_EN` defined:
  - breakpoint comparator, armed flag and `bp_hit_out` behave as above.
- Not defined:
  - `bp_addr_in` and `bp_en_in` are ignored, `bp_hit_out` is tied to 0, and `cpu_step_out` is purely state-decoded.
  - The port list is unchanged in both builds.

## Test plan
- Reset release with `RESET_CYCLES` = 16, no commands → `cpu_rst_out` high for 16 edges, then `state_out` = 0, `cpu_step_out` = 0, `step_count_out` = 0.
- `start_in` pulse, wait 100 cycles, `halt_in` pulse → `step_count_out` = 101, then `state_out` = 0; `start_in` with `force_halt_in` = 1 → stays HALT.
- Three `step_in` pulses spaced 5 cycles apart → three single-cycle `cpu_step_out` highs, `step_count_out` = 3; a simultaneous `step_in` + `start_in` → RUN.
- Breakpoint build: `bp_addr_in` = 0x0000_0040, `bp_en_in` = 1, PC model advances 4 per step from 0 → halts with `pc_in` = 0x40, `bp_hit_out` = 1, 16 steps counted. `start_in` → resumes, no re-hit until PC leaves 0x40 and returns.
- `reset_req_in` during RUN with a simultaneous `halt_in` → `cpu_step_out` = 0 at once, RESETTING for 16 cycles, counters cleared; `rst_in` asserted mid-RESETTING → counter reloaded asynchronously.
- Wrap: preload the count near 0xFFFF_FFFF via a long run (or force) → wraps to 0 without a state change.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: owns the core step enable and reset (HALT/RUN/STEP/RESETTING).
// Optional PC breakpoint is compiled in with `define CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        halt_in,
    input  logic        reset_req_in,
    input  logic        step_in,
    input  logic        force_halt_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] bp_addr_in,
    input  logic        bp_en_in,
    output logic        cpu_step_out,
    output logic        cpu_rst_out,
    output logic [1:0]  state_out,
    output logic        bp_hit_out,
    output logic [31:0] step_count_out
);
    localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RC_LOAD = RCW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_RESET = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           bp_hit_q, bp_hit_d;
    logic           hit;
    logic           step;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic armed_q, armed_d;
    logic pc_match;

    assign pc_match = (pc_in[31:2] == bp_addr_in[31:2]);
    assign hit      = (state_q == S_RUN) && bp_en_in && armed_q && pc_match;

    // Disarm on a hit so a later start resumes past the breakpoint instruction.
    always_comb begin
        armed_d = armed_q;
        if (hit)
            armed_d = 1'b0;
        else if (!pc_match)
            armed_d = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) armed_q <= 1'b1;
        else        armed_q <= armed_d;
    end

    assign bp_hit_out = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp  = ^{pc_in, bp_addr_in, bp_en_in, bp_hit_q};
    assign hit        = 1'b0;
    assign bp_hit_out = 1'b0;
`endif

    assign step           = (state_q == S_STEP) || ((state_q == S_RUN) && !hit);
    assign cpu_step_out   = step;
    assign cpu_rst_out    = (state_q == S_RESET);
    assign state_out      = state_q;
    assign step_count_out = cnt_q;

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        cnt_d    = cnt_q + {31'd0, step};
        bp_hit_d = bp_hit_q;
        if (reset_req_in) begin
            state_d = S_RESET;
            rcnt_d  = RC_LOAD;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    if (rcnt_q == '0) begin
                        state_d  = S_HALT;
                        cnt_d    = '0;
                        bp_hit_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q - 1'b1;
                    end
                end
                S_HALT: begin
                    // Step stays legal under force-halt; only start is blocked by it.
                    if (halt_in) begin
                        state_d = S_HALT;
                    end else if (start_in && !force_halt_in) begin
                        state_d  = S_RUN;
                        bp_hit_d = 1'b0;
                    end else if (step_in) begin
                        state_d  = S_STEP;
                        bp_hit_d = 1'b0;
                    end
                end
                S_STEP: state_d = S_HALT;
                S_RUN: begin
                    if (hit) begin
                        state_d  = S_HALT;
                        bp_hit_d = 1'b1;
                    end
                    if (halt_in || force_halt_in)
                        state_d = S_HALT;
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_RESET;
            rcnt_q   <= RC_LOAD;
            cnt_q    <= '0;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            cnt_q    <= cnt_d;
            bp_hit_q <= bp_hit_d;
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a rule-level model predicts outputs per edge,
// a monitor compares them; directed scenarios followed by randomized commands.
module tb_cpu_run_ctrl;
    localparam int RC = 16;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start_in = 1'b0, halt_in = 1'b0, reset_req_in = 1'b0, step_in = 1'b0;
    logic        force_halt_in = 1'b0;
    logic [31:0] pc_in = '0, bp_addr_in = 32'h40;
    logic        bp_en_in = 1'b0;
    logic        cpu_step_out, cpu_rst_out, bp_hit_out;
    logic [1:0]  state_out;
    logic [31:0] step_count_out;

    cpu_run_ctrl #(.RESET_CYCLES(RC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .halt_in(halt_in),
        .reset_req_in(reset_req_in), .step_in(step_in), .force_halt_in(force_halt_in),
        .pc_in(pc_in), .bp_addr_in(bp_addr_in), .bp_en_in(bp_en_in),
        .cpu_step_out(cpu_step_out), .cpu_rst_out(cpu_rst_out), .state_out(state_out),
        .bp_hit_out(bp_hit_out), .step_count_out(step_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        step;
        logic        rst;
        logic [1:0]  st;
        logic        bph;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pc_mode = 0;   // 0: random PC, 1: PC = 4 * steps since reset

    // Reference model: 0 HALT, 1 RUN, 2 STEP, 3 RESETTING
    int          m_st = 3;
    int          m_rc = RC - 1;
    logic [31:0] m_cnt = '0;
    bit          m_bph = 1'b0;
    bit          m_arm = 1'b1;

    function automatic bit m_hit();
        return BP && m_st == 1 && bp_en_in && m_arm && (pc_in[31:2] == bp_addr_in[31:2]);
    endfunction

    function automatic bit m_step();
        return (m_st == 2) || (m_st == 1 && !m_hit());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit hit, stp, match;
        match = (pc_in[31:2] == bp_addr_in[31:2]);
        hit   = m_hit();
        stp   = m_step();
        if (stp) m_cnt = m_cnt + 1;
        if (hit) m_arm = 1'b0;
        else if (!match) m_arm = 1'b1;
        if (reset_req_in) begin
            m_st = 3;
            m_rc = RC - 1;
        end else begin
            case (m_st)
                3: if (m_rc == 0) begin m_st = 0; m_cnt = 0; m_bph = 0; end
                   else m_rc--;
                0: if (halt_in) m_st = 0;
                   else if (start_in && !force_halt_in) begin m_st = 1; m_bph = 0; end
                   else if (step_in) begin m_st = 2; m_bph = 0; end
                2: m_st = 0;
                default: begin
                    if (hit) begin m_st = 0; m_bph = 1; end
                    if (halt_in || force_halt_in) m_st = 0;
                end
            endcase
        end
    endtask

    // One clock: drive at negedge, check the combinational step path, model the edge.
    task automatic cyc(input bit rs = 0, input bit ha = 0, input bit st = 0, input bit sp = 0);
        exp_t e;
        reset_req_in = rs; halt_in = ha; start_in = st; step_in = sp;
        if (pc_mode == 1) pc_in = m_cnt << 2;
        #1;
        chk("comb_step", {31'd0, cpu_step_out}, {31'd0, m_step()});
        @(posedge clk_in);
        model_edge();
        e.step = m_step(); e.rst = (m_st == 3); e.st = m_st[1:0]; e.bph = BP ? m_bph : 1'b0;
        e.cnt = m_cnt;
        q.push_back(e);
        @(negedge clk_in);
        reset_req_in = 0; halt_in = 0; start_in = 0; step_in = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        #1;
        chk("arst_state", {30'd0, state_out}, 32'd3);
        chk("arst_cpu_rst", {31'd0, cpu_rst_out}, 32'd1);
        chk("arst_step", {31'd0, cpu_step_out}, 32'd0);
        chk("arst_count", step_count_out, 32'd0);
        chk("arst_bphit", {31'd0, bp_hit_out}, 32'd0);
        m_st = 3; m_rc = RC - 1; m_cnt = 0; m_bph = 0; m_arm = 1;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({cpu_step_out, cpu_rst_out, state_out, bp_hit_out, step_count_out} !== e) begin
                    failures++;
                    $display("FAIL scoreboard: got step=%b rst=%b st=%0d bph=%b cnt=%h expected step=%b rst=%b st=%0d bph=%b cnt=%h at %0t",
                             cpu_step_out, cpu_rst_out, state_out, bp_hit_out, step_count_out,
                             e.step, e.rst, e.st, e.bph, e.cnt, $time);
                end
            end
        end
    end

    initial begin : stim
        @(negedge clk_in);
        do_reset();
        // Reset release: 16 edges of core reset then HALT
        idle(RC - 1);
        chk("still_resetting", {31'd0, cpu_rst_out}, 32'd1);
        idle(1);
        chk("rel_state", {30'd0, state_out}, 32'd0);
        idle(3);

        // Run 101 steps then halt; start under force-halt ignored
        cyc(.st(1));
        idle(100);
        cyc(.ha(1));
        chk("run_count", step_count_out, 32'd101);
        chk("run_halted", {30'd0, state_out}, 32'd0);
        force_halt_in = 1'b1;
        cyc(.st(1));
        idle(2);
        chk("force_blocks_start", {30'd0, state_out}, 32'd0);
        force_halt_in = 1'b0;

        // Three single steps, then start+step together
        for (int i = 0; i < 3; i++) begin
            cyc(.sp(1));
            idle(4);
        end
        chk("step_count", step_count_out, 32'd104);
        cyc(.st(1), .sp(1));
        chk("start_beats_step", {30'd0, state_out}, 32'd1);
        idle(3);
        cyc(.ha(1));

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        do_reset();
        idle(RC + 1);
        pc_mode = 1; bp_addr_in = 32'h40; bp_en_in = 1'b1;
        cyc(.st(1));
        for (int i = 0; i < 40 && m_st != 0; i++) cyc();
        chk("bp_halt_state", {30'd0, state_out}, 32'd0);
        chk("bp_pc", pc_in, 32'h40);
        chk("bp_hit", {31'd0, bp_hit_out}, 32'd1);
        chk("bp_count", step_count_out, 32'd16);
        cyc(.st(1));
        idle(8);
        chk("bp_resumed", {30'd0, state_out}, 32'd1);
        cyc(.ha(1));
        pc_mode = 0; bp_en_in = 1'b0;
`endif

        // Reset request with simultaneous halt during RUN, then async reset mid-RESETTING
        cyc(.st(1));
        idle(5);
        cyc(.rs(1), .ha(1));
        chk("rr_step_drop", {31'd0, cpu_step_out}, 32'd0);
        idle(RC);
        chk("rr_cleared", step_count_out, 32'd0);
        cyc(.rs(1));
        idle(5);
        do_reset();
        idle(RC + 2);

        // Wrap of the step counter while running
        cyc(.st(1));
        force dut.cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFD;
        if (q.size() > 0) q[q.size()-1].cnt = m_cnt;
        idle(5);
        chk("wrap_count", step_count_out, 32'd2);
        chk("wrap_state", {30'd0, state_out}, 32'd1);
        cyc(.ha(1));

        // Randomized commands
        for (int i = 0; i < 2500; i++) begin
            bit rs, ha, st, sp;
            if ($urandom_range(0, 31) == 0) force_halt_in = ~force_halt_in;
            if ($urandom_range(0, 15) == 0) bp_en_in = ~bp_en_in;
            pc_in = ($urandom_range(0, 2) == 0) ? {bp_addr_in[31:2], 2'($urandom)} : $urandom;
            rs = ($urandom_range(0, 99) == 0);
            ha = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 7) == 0);
            cyc(rs, ha, st, sp);
        end

        @(posedge clk_in);
        #2;
        chk("sb_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
